alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
Parametrised, registered successor to the LC-3 datapath ALU. It adds SUB, an iterative barrel-free left shift, an iterative shift-add multiply, a start/busy/done handshake and registered NZP condition codes. It sits between the register file / SR2 mux and the bus gate. Single-cycle ops stream back-to-back; SHL and MUL stall the FSM via busy.

Parameters:
WIDTH, 16, datapath width in bits (>= 4).
MUL_EN, 1, 1 = MUL op implemented; 0 = op 110 behaves as reserved.

Ports:
Clk  in  1  system clock; all state updates on rising edge.
Reset  in  1  synchronous, active-high reset.
start  in  1  request; sampled only when busy=0.
op  in  3  000 ADD, 001 AND, 010 NOT A, 011 PASS A, 100 SUB A-B, 101 SHL, 110 MUL, 111 reserved.
A  in  WIDTH  operand A (SR1OUT).
B  in  WIDTH  operand B (SR2MUX out).
busy  out  1  high while a multi-cycle op is in progress.
done  out  1  one-cycle pulse; result and nzp are valid and updated.
result  out  WIDTH  registered result; holds until the next done.
nzp  out  3  {N,Z,P} of result; updated together with result.

Behaviour:
- Reset: one clock is the only clock domain; reset is synchronous and active-high. Reset has priority over everything, including mid-operation. On reset: state IDLE, busy=0, done=0, result=0, nzp=000. Any in-flight op is discarded with no done.
- Accept: edge E0 with start=1 and busy=0. A, B and op are latched at E0; later input changes do not affect the op. start while busy=1 is ignored and not queued.
- Single-cycle ops (ADD, AND, NOT, PASS, SUB, SHL with shamt=0, reserved, MUL with MUL_EN=0):
  - result is written at E0; done=1 in the cycle after E0; busy stays 0.
  - Back-to-back accepts on consecutive edges give a done every cycle.
- Arithmetic: ADD/SUB are modulo 2^WIDTH; carry and overflow are discarded. Reserved op gives result 0 (nzp=010).
- SHL:
  - shamt = B[$clog2(WIDTH)-1:0]; the rest of B is ignored.
  - shamt>0: state SHIFT, busy=1 from the cycle after E0. One bit shifted per edge, zero-fill.
  - At edge E_shamt: result written, busy drops, done=1 the following cycle.
- MUL (MUL_EN=1):
  - State MUL; unsigned shift-add, one multiplier bit per edge.
  - busy=1 for WIDTH cycles. Result = low WIDTH bits of A*B, written at edge E_WIDTH; done the following cycle.
  - Signed operands give the correct low half (two's complement property).
- FSM: IDLE -(accept SHL shamt>0)-> SHIFT -(count==shamt)-> IDLE; IDLE -(accept MUL)-> MUL -(count==WIDTH)-> IDLE. The count register is $clog2(WIDTH)+1 bits.
- done is high exactly one cycle per accepted op. done and busy are never both high.
- NZP: N=result[WIDTH-1]; Z=(result==0); P=otherwise. Exactly one bit is set after the first done.
- A new start can be accepted on the same edge that completes a multi-cycle op only if busy already reads 0 that cycle, i.e. no overlap.

Test Plan:
- Reset mid-MUL: A=3,B=5, assert Reset at E4 -> no done, result=0, nzp=000, busy=0 next cycle.
- Back-to-back: ADD 0x7FFF+1, SUB 5-7, AND 0xF0F0&0x0FF0 on consecutive edges -> done three cycles running: 0x8000 nzp=100; 0xFFFE nzp=100; 0x00F0 nzp=001.
- SHL: A=0x0003, B=0x0004 -> busy 4 cycles, result 0x0030; B=0x0010 (shamt 0) -> 1-cycle done, result 0x0003.
- MUL: A=0x0123, B=0x0010 -> busy exactly 16 cycles, result 0x1230; A=0xFFFF (-1), B=0x0002 -> 0xFFFE, nzp=100.
- start during busy with op=ADD -> ignored; exactly one done, carrying the MUL result. NOT 0xFFFF -> 0x0000, nzp=010.
- MUL_EN=0 build: op 110 -> single-cycle done, result 0; op 111 -> result 0, nzp=010.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - start/busy/done request bus for the multi-cycle ALU
// The master drives the request and operands; the slave returns status, result and condition codes.
interface alu_multicycle_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [2:0]       nzp;

  modport master (
    output start, op, A, B,
    input  busy, done, result, nzp
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, result, nzp
  );
endinterface

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - registered ALU with iterative SHL/MUL and NZP codes
// Single-cycle ops complete on the accept edge; SHL and MUL iterate one bit per clock while busy.
module alu_multicycle #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  alu_multicycle_if.slave   bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       nzp_q, nzp_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    shamt_q, shamt_d;
  logic [CW-1:0]    count_inc;
  logic [WIDTH-1:0] acc_sum;
  logic             finish;

  function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] r);
    logic n, z;
    n = r[WIDTH-1];
    z = (r == '0);
    return {n, z, ~n & ~z};
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      nzp_q    <= 3'b000;
      done_q   <= 1'b0;
      work_q   <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      shamt_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      nzp_q    <= nzp_d;
      done_q   <= done_d;
      work_q   <= work_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      shamt_q  <= shamt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    nzp_d     = nzp_q;
    done_d    = 1'b0;
    work_d    = work_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    shamt_d   = shamt_q;
    finish    = 1'b0;
    count_inc = count_q + CW'(1);
    acc_sum   = acc_q + (mplier_q[0] ? work_q : '0);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'b000: begin result_d = bus.A + bus.B; finish = 1'b1; end
            3'b001: begin result_d = bus.A & bus.B; finish = 1'b1; end
            3'b010: begin result_d = ~bus.A;        finish = 1'b1; end
            3'b011: begin result_d = bus.A;         finish = 1'b1; end
            3'b100: begin result_d = bus.A - bus.B; finish = 1'b1; end
            3'b101: begin
              if (bus.B[SW-1:0] == '0) begin
                result_d = bus.A;
                finish   = 1'b1;
              end else begin
                state_d = ST_SHIFT;
                work_d  = bus.A;
                shamt_d = bus.B[SW-1:0];
                count_d = '0;
              end
            end
            3'b110: begin
              if (MUL_EN) begin
                state_d  = ST_MUL;
                work_d   = bus.A;
                mplier_d = bus.B;
                acc_d    = '0;
                count_d  = '0;
              end else begin
                result_d = '0;
                finish   = 1'b1;
              end
            end
            default: begin result_d = '0; finish = 1'b1; end
          endcase
        end
      end

      ST_SHIFT: begin
        work_d  = work_q << 1;
        count_d = count_inc;
        if (count_inc == {1'b0, shamt_q}) begin
          result_d = work_q << 1;
          state_d  = ST_IDLE;
          finish   = 1'b1;
        end
      end

      ST_MUL: begin
        // Multiplicand walks left while the multiplier drains right, one partial product per clock.
        acc_d    = acc_sum;
        work_d   = work_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_inc;
        if (count_inc == CW'(WIDTH)) begin
          result_d = acc_sum;
          state_d  = ST_IDLE;
          finish   = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      done_d = 1'b1;
      nzp_d  = nzp_of(result_d);
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.nzp    = nzp_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle with MUL_EN=1 and MUL_EN=0 instances
module tb_alu_multicycle;
  typedef struct {
    logic [15:0] res;
    logic [2:0]  nzp;
    int          busy;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  alu_multicycle_if #(.WIDTH(16)) b0 ();
  alu_multicycle_if #(.WIDTH(16)) b1 ();

  alu_multicycle #(.WIDTH(16), .MUL_EN(1'b1)) dut0 (.Clk(Clk), .Reset(Reset), .bus(b0));
  alu_multicycle #(.WIDTH(16), .MUL_EN(1'b0)) dut1 (.Clk(Clk), .Reset(Reset), .bus(b1));

  int   n_checks = 0;
  int   n_fail   = 0;
  int   bc0      = 0;
  int   bc1      = 0;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic on_done(input int d, input logic [15:0] res, input logic [2:0] nzp,
                         input int bc, input logic busy);
    exp_t e;
    chk($sformatf("dut%0d done_and_busy", d), {31'd0, busy}, 32'd0);
    n_checks++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL dut%0d unexpected_done: got result 0x%0h, expected no done", d, res);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("dut%0d result", d), {16'd0, res}, {16'd0, e.res});
      chk($sformatf("dut%0d nzp", d), {29'd0, nzp}, {29'd0, e.nzp});
      chk($sformatf("dut%0d busy_cycles", d), bc, e.busy);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset) begin
      bc0 = 0;
      bc1 = 0;
    end else begin
      if (b0.busy === 1'b1) bc0++;
      if (b1.busy === 1'b1) bc1++;
      if (b0.done === 1'b1) begin
        on_done(0, b0.result, b0.nzp, bc0, b0.busy);
        bc0 = 0;
      end
      if (b1.done === 1'b1) begin
        on_done(1, b1.result, b1.nzp, bc1, b1.busy);
        bc1 = 0;
      end
    end
  end

  task automatic issue0(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic [2:0] en, input int eb);
    q0.push_back('{er, en, eb});
    b0.start = 1'b1;
    b0.op    = op;
    b0.A     = a;
    b0.B     = b;
    @(posedge Clk);
    #1;
    b0.start = 1'b0;
    b0.A     = 16'hDEAD;
    b0.B     = 16'hBEEF;
  endtask

  task automatic issue1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic [2:0] en, input int eb);
    q1.push_back('{er, en, eb});
    b1.start = 1'b1;
    b1.op    = op;
    b1.A     = a;
    b1.B     = b;
    @(posedge Clk);
    #1;
    b1.start = 1'b0;
    b1.A     = 16'hDEAD;
    b1.B     = 16'hBEEF;
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while (b0.busy === 1'b1 && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("dut0 idle_timeout", {31'd0, b0.busy}, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.start = 1'b0; b0.op = 3'b000; b0.A = '0; b0.B = '0;
    b1.start = 1'b0; b1.op = 3'b000; b1.A = '0; b1.B = '0;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    chk("reset busy",   {31'd0, b0.busy}, 32'd0);
    chk("reset done",   {31'd0, b0.done}, 32'd0);
    chk("reset result", {16'd0, b0.result}, 32'd0);
    chk("reset nzp",    {29'd0, b0.nzp}, 32'd0);
    chk("reset1 result", {16'd0, b1.result}, 32'd0);
    chk("reset1 nzp",    {29'd0, b1.nzp}, 32'd0);

    // back-to-back single-cycle ops
    issue0(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 3'b100, 0);
    issue0(3'b100, 16'h0005, 16'h0007, 16'hFFFE, 3'b100, 0);
    issue0(3'b001, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b001, 0);
    issue0(3'b010, 16'hFFFF, 16'h0000, 16'h0000, 3'b010, 0);
    issue0(3'b011, 16'h1234, 16'h5555, 16'h1234, 3'b001, 0);
    issue0(3'b111, 16'h0005, 16'h0005, 16'h0000, 3'b010, 0);
    idle_cycles(2);

    // shifts
    issue0(3'b101, 16'h0003, 16'h0004, 16'h0030, 3'b001, 4);
    wait_idle0();
    issue0(3'b101, 16'h0003, 16'h0010, 16'h0003, 3'b001, 0);
    issue0(3'b101, 16'h0001, 16'hFFFF, 16'h8000, 3'b100, 15);
    wait_idle0();
    idle_cycles(2);

    // multiplies
    issue0(3'b110, 16'h0123, 16'h0010, 16'h1230, 3'b001, 16);
    wait_idle0();
    issue0(3'b110, 16'hFFFF, 16'h0002, 16'hFFFE, 3'b100, 16);
    wait_idle0();
    idle_cycles(2);

    // start while busy must be dropped
    issue0(3'b110, 16'h0007, 16'h0009, 16'h003F, 3'b001, 16);
    idle_cycles(3);
    b0.start = 1'b1; b0.op = 3'b000; b0.A = 16'h0001; b0.B = 16'h0001;
    @(posedge Clk);
    #1;
    b0.start = 1'b0;
    wait_idle0();
    idle_cycles(4);

    // reset in the middle of a multiply
    b0.start = 1'b1; b0.op = 3'b110; b0.A = 16'h0003; b0.B = 16'h0005;
    @(posedge Clk);
    #1;
    b0.start = 1'b0;
    chk("mid_mul busy", {31'd0, b0.busy}, 32'd1);
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk("mid_mul reset busy",   {31'd0, b0.busy}, 32'd0);
    chk("mid_mul reset done",   {31'd0, b0.done}, 32'd0);
    chk("mid_mul reset result", {16'd0, b0.result}, 32'd0);
    chk("mid_mul reset nzp",    {29'd0, b0.nzp}, 32'd0);
    idle_cycles(20);

    // MUL_EN=0 instance
    issue1(3'b110, 16'h0003, 16'h0005, 16'h0000, 3'b010, 0);
    issue1(3'b111, 16'h0003, 16'h0005, 16'h0000, 3'b010, 0);
    issue1(3'b000, 16'h0002, 16'h0003, 16'h0005, 3'b001, 0);
    idle_cycles(3);

    chk("dut0 pending_expected", q0.size(), 32'd0);
    chk("dut1 pending_expected", q1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
